// File: rtl/carrier_loop_filter.sv
// PI carrier-recovery loop filter: phase error in, signed NCO frequency word out.
// Wide acquisition gains switch to narrow tracking gains under a lock detector.
module carrier_loop_filter #(
    parameter int ERR_W      = 10,
    parameter int FREQ_W     = 30,
    parameter int ACQ_KP_SH  = 4,
    parameter int ACQ_KI_SH  = 10,
    parameter int TRK_KP_SH  = 6,
    parameter int TRK_KI_SH  = 14,
    parameter int LOCK_TH    = 64,
    parameter int LOCK_CNT   = 256,
    parameter int UNLOCK_CNT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clken,
    input  logic                     clear_i,
    input  logic signed [ERR_W-1:0]  err_i,
    input  logic                     err_valid_i,
    output logic signed [FREQ_W-1:0] freq_mod_o,
    output logic                     freq_valid_o,
    output logic                     lock_o,
    output logic [1:0]               state_o
);

    localparam int W   = FREQ_W + 2;
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam int UCW = $clog2(UNLOCK_CNT + 1);
    localparam logic signed [W-1:0] SAT_MAX = {3'b000, {(FREQ_W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = -SAT_MAX;
    localparam logic [ERR_W:0] LOCK_TH_V = (ERR_W+1)'(LOCK_TH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACQ  = 2'b01,
        S_TRK  = 2'b10
    } state_t;

    state_t                    state_q, state_d;
    logic [LCW-1:0]            lock_cnt_q, lock_cnt_d;
    logic [UCW-1:0]            unlock_cnt_q, unlock_cnt_d;
    logic signed [FREQ_W-1:0]  integ_q, integ_d;
    logic signed [W-1:0]       prop_q, prop_d;
    logic                      v1_q, v1_d;
    logic                      v2_q, v2_d;
    logic signed [FREQ_W-1:0]  freq_q, freq_d;

    logic signed [W-1:0]       err_ext, e, prop, inc, integ_ext;
    logic signed [ERR_W:0]     err_wide;
    logic [ERR_W:0]            err_abs;
    logic                      in_lock;

    // Symmetric clamp keeps the NCO word free of the lone most-negative code.
    function automatic logic signed [FREQ_W-1:0] sat(input logic signed [W-1:0] x);
        if (x > SAT_MAX)
            return SAT_MAX[FREQ_W-1:0];
        else if (x < SAT_MIN)
            return SAT_MIN[FREQ_W-1:0];
        else
            return x[FREQ_W-1:0];
    endfunction

    always_comb begin
        err_ext   = {{(W-ERR_W){err_i[ERR_W-1]}}, err_i};
        e         = err_ext <<< (FREQ_W - ERR_W);
        prop      = (state_q == S_TRK) ? (e >>> TRK_KP_SH) : (e >>> ACQ_KP_SH);
        inc       = (state_q == S_TRK) ? (e >>> TRK_KI_SH) : (e >>> ACQ_KI_SH);
        integ_ext = {{2{integ_q[FREQ_W-1]}}, integ_q};
        err_wide  = {err_i[ERR_W-1], err_i};
        err_abs   = err_i[ERR_W-1] ? 11'(-err_wide) : 11'(err_wide);
        in_lock   = (err_abs < LOCK_TH_V);
    end

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        integ_d      = integ_q;
        prop_d       = prop_q;
        v1_d         = v1_q;
        v2_d         = v2_q;
        freq_d       = freq_q;
        if (clken) begin
            if (clear_i) begin
                state_d      = S_IDLE;
                lock_cnt_d   = '0;
                unlock_cnt_d = '0;
                integ_d      = '0;
                prop_d       = '0;
                v1_d         = 1'b0;
                v2_d         = 1'b0;
                freq_d       = '0;
            end else begin
                v1_d = err_valid_i;
                v2_d = v1_q;
                if (v1_q)
                    freq_d = sat(integ_ext + prop_q);
                if (err_valid_i) begin
                    integ_d = sat(integ_ext + inc);
                    prop_d  = prop;
                    case (state_q)
                        S_IDLE: begin
                            state_d      = S_ACQ;
                            lock_cnt_d   = in_lock ? LCW'(1) : '0;
                            unlock_cnt_d = '0;
                        end
                        S_ACQ: begin
                            if (!in_lock)
                                lock_cnt_d = '0;
                            else if (lock_cnt_q == LCW'(LOCK_CNT - 1)) begin
                                state_d      = S_TRK;
                                lock_cnt_d   = '0;
                                unlock_cnt_d = '0;
                            end else
                                lock_cnt_d = lock_cnt_q + LCW'(1);
                        end
                        S_TRK: begin
                            if (in_lock)
                                unlock_cnt_d = '0;
                            else if (unlock_cnt_q == UCW'(UNLOCK_CNT - 1)) begin
                                state_d      = S_ACQ;
                                lock_cnt_d   = '0;
                                unlock_cnt_d = '0;
                            end else
                                unlock_cnt_d = unlock_cnt_q + UCW'(1);
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
            integ_q      <= '0;
            prop_q       <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            freq_q       <= '0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
            integ_q      <= integ_d;
            prop_q       <= prop_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            freq_q       <= freq_d;
        end
    end

    // The strobe is gated so a frozen pipeline never re-issues the same word.
    assign freq_mod_o   = freq_q;
    assign freq_valid_o = v2_q & clken;
    assign lock_o       = (state_q == S_TRK);
    assign state_o      = state_q;

endmodule

// File: doc/carrier_loop_filter.md
Name: carrier_loop_filter

Overview:
- Proportional-integral carrier-recovery loop filter for the DQPSK demodulator.
- Takes signed phase-error samples from the phase detector and produces the signed frequency-modulation word that drives the NCO's freq_mod_i input, with a valid strobe.
- Switches between wide-band acquisition gains and narrow-band tracking gains using a lock detector.

Parameters:
- ERR_W, 10, phase-error width (signed two's complement).
- FREQ_W, 30, output frequency word width; matches the NCO phase accumulator.
- ACQ_KP_SH, 4, proportional right-shift in ACQUIRE.
- ACQ_KI_SH, 10, integral right-shift in ACQUIRE.
- TRK_KP_SH, 6, proportional right-shift in TRACK.
- TRK_KI_SH, 14, integral right-shift in TRACK.
- LOCK_TH, 64, |err| strictly below this counts as in-lock.
- LOCK_CNT, 256, consecutive in-lock samples needed to enter TRACK.
- UNLOCK_CNT, 64, consecutive out-of-lock samples needed to fall back to ACQUIRE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- clken  in  1  clock enable; when low all state holds and err_valid_i is ignored.
- clear_i  in  1  synchronous loop clear.
- err_i  in  ERR_W  signed phase error.
- err_valid_i  in  1  err_i qualifier; one sample accepted per cycle.
- freq_mod_o  out  FREQ_W  signed frequency word to NCO freq_mod_i.
- freq_valid_o  out  1  one-cycle strobe; freq_mod_o updated.
- lock_o  out  1  high while state is TRACK.
- state_o  out  2  00 IDLE, 01 ACQUIRE, 10 TRACK.

Behaviour:
- Reset (rst=1, asynchronous):
  - freq_mod_o=0, freq_valid_o=0, lock_o=0, state_o=IDLE.
  - Integrator=0, both counters=0, pipeline valids=0.
- Sample accepted: clken=1, err_valid_i=1, clear_i=0.
- Scaling:
  - e = sign-extend(err_i) << (FREQ_W-ERR_W), held in FREQ_W+2 bits.
  - prop = e >>> KP_SH; inc = e >>> KI_SH (arithmetic shifts).
  - KP_SH/KI_SH are the gains of the state at acceptance time.
- Stage 1 (cycle after accept):
  - integ <= sat(integ + inc); prop registered.
  - sat clamps symmetrically to ±(2^(FREQ_W-1)-1).
- Stage 2:
  - freq_mod_o <= sat(integ + prop).
  - freq_valid_o=1 for exactly one cycle.
- Latency: 2 clock-enabled cycles from accept to freq_valid_o. Throughput 1 sample/cycle. freq_mod_o holds its value between strobes.
- State machine (updates registered the cycle after accept, in parallel with stage 1):
  - IDLE -> ACQUIRE on first accepted sample; that sample is filtered with ACQ gains.
  - ACQUIRE:
    - |err|<LOCK_TH increments lock_cnt; otherwise lock_cnt clears.
    - lock_cnt reaching LOCK_CNT -> TRACK, lock_o=1, both counters cleared.
  - TRACK:
    - |err|>=LOCK_TH increments unlock_cnt; otherwise unlock_cnt clears.
    - unlock_cnt reaching UNLOCK_CNT -> ACQUIRE, lock_o=0, counters cleared.
  - New gains apply from the next accepted sample. The integrator is never reset on a state change.
- |err| is computed in ERR_W+1 bits, so err=-2^(ERR_W-1) gives 2^(ERR_W-1) and no overflow.
- clear_i=1 with clken=1:
  - Integrator, counters and pipeline valids go to 0; state -> IDLE; lock_o=0.
  - freq_mod_o <= 0, with no freq_valid_o strobe.
  - Any simultaneous err_valid_i sample is discarded; in-flight samples are dropped.
- clken=0: pipeline, counters, state and outputs frozen; freq_valid_o is forced low during those cycles and resumes on re-enable.
- Reset asserted mid-pipeline: immediate return to reset values; no strobe for in-flight samples.

Test Plan:
- Reset, then idle 10 cycles -> freq_mod_o=0, freq_valid_o=0, lock_o=0, state_o=00.
- Single err=1 after reset (ACQ: e=2^20) -> 2 cycles later freq_valid_o pulse, freq_mod_o=65536+1024=66560; state_o=01.
- err=511 every cycle for 1100 samples -> freq_mod_o rises monotonically, then stays at 536870911. Repeat with err=-512 -> stays at -536870911.
- 256 consecutive err=0 -> state_o=10 and lock_o=1 the cycle after the 256th accept. Then 63x err=100 keeps TRACK; the 64th gives state_o=01 and lock_o=0. 255 zeros, one err=64, 256 zeros -> TRACK only after the final 256.
- Streaming err=5 with clear_i pulsed alongside a valid sample -> that sample produces no strobe; freq_mod_o=0, state_o=00; the next sample produces a strobe of (5<<20)>>>4 + (5<<20)>>>10 = 327680+5120 = 332800.
- clken low for 3 cycles mid-pipeline -> outputs frozen and no strobe; the pending strobe appears 2 enabled cycles after accept. rst asserted mid-stream -> all outputs 0 asynchronously.
